bcd_converter: RTL and testbench
================================

# bcd_converter

Sequential binary-to-BCD converter on the read side of the 8-bit holding register. It accepts the register's parallel word through a valid/ready handshake, converts it with the shift-and-add-3 (double-dabble) algorithm at one bit per cycle, and presents the packed decimal digits to the display/formatting logic through a second valid/ready handshake. One conversion is in flight at a time.

## Interface
- `WIDTH`, 8: width of the binary input word.
- `DIGITS`, 3: number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. 0 clears all state immediately; release is synchronous to `clk`.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word; high only in IDLE.
- `in_data`  in  WIDTH  binary word (register output).
- `out_valid`  out  1  `out_bcd`/`out_neg` hold a completed result.
- `out_ready`  in  1  consumer takes the result.
- `out_bcd`  out  4*DIGITS  packed BCD, digit 0 (ones) in bits [3:0].
- `out_neg`  out  1  result is negative (see Configuration).
- `busy`  out  1  high in SHIFT or DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: `in_ready`=1. On `in_valid`&`in_ready` at an edge: capture `in_data` into the shift source, clear the BCD accumulator, load bit counter with WIDTH, go to SHIFT.
- SHIFT: each cycle, every 4-bit accumulator digit >= 5 gets +3 (all digits corrected in parallel, from the pre-shift value), then {accumulator, source} shifts left by one; counter decrements. On the edge where the counter goes 1 -> 0 (the WIDTH-th shift), copy the final accumulator into `out_bcd`, go to DONE.
- DONE: `out_valid`=1; `out_bcd`/`out_neg` stable. On `out_ready`=1 at an edge, go to IDLE.
- `out_bcd`/`out_neg` are registered and change only on entry to DONE; they keep the last result through IDLE and SHIFT.
- `in_valid` while not in IDLE is ignored (`in_ready`=0); no data is lost because the producer must hold it.
- Digit arithmetic is 4-bit unsigned; the +3 correction never overflows a digit because the threshold is 5.
- Unused upper digits (e.g., hundreds for values < 100) read 0.
- Reset values: `in_ready`=0 while reset is asserted and 1 in IDLE after release; `out_valid`=0, `out_bcd`=0, `out_neg`=0, `busy`=0; state IDLE.
- Reset mid-SHIFT or mid-DONE: conversion is discarded, outputs return to reset values, and no partial result is ever presented.

## Timing
- Accept at edge 0 -> `out_valid` rises after edge WIDTH (8 cycles for the default).
- DONE with `out_ready` already high: one cycle in DONE, IDLE on the next edge; next accept one edge later. Minimum initiation interval is WIDTH+2 cycles.
- `out_ready` held low: DONE persists indefinitely with outputs stable.
- `in_ready` and `out_valid` are never both high.

## Configuration
- `BCD_SIGNED_EN` defined: `in_data` is two's complement. On capture, the MSB is stored as the sign and the source is loaded with the magnitude (the negated value when negative). The most negative value -2^(WIDTH-1) converts correctly as an unsigned magnitude. `out_neg` carries the sign with the result and is 0 for zero.
- Not defined: `in_data` is unsigned, `out_neg` is tied to 0, and no negation logic is built.

## Structure
- Shared package `conv_pkg` holds the FSM state encoding (IDLE/SHIFT/DONE), `BCD_DIGIT_W`=4, and the add-3 threshold constant 5.
- Sub-module `bcd_add3`: combinational per-digit correction (4-bit in, 4-bit out), instantiated DIGITS times.

## Test plan
- `in_data`=8'd0, then 8'd255 with `out_ready`=1 -> `out_bcd`=12'h000, then 12'h255; each with `out_valid` exactly 8 cycles after accept.
- `in_data`=8'd99 and 8'd100 -> 12'h099 and 12'h100; `in_ready` low throughout each conversion.
- Backpressure: convert 8'd42 with `out_ready`=0 for 20 cycles -> `out_valid` stays high with 12'h042 stable; a new `in_valid` is not accepted until one edge after `out_ready`=1.
- Assert reset 4 cycles into converting 8'd200 -> `out_valid`=0 and `out_bcd`=0 immediately; after release, converting 8'd7 gives 12'h007.
- `BCD_SIGNED_EN`: 8'h80 -> `out_neg`=1, 12'h128; 8'hFF -> `out_neg`=1, 12'h001; 8'h00 -> `out_neg`=0, 12'h000; 8'h7F -> `out_neg`=0, 12'h127.
- Back-to-back: `in_valid` and `out_ready` held high with 1, 2, 3 -> results 001, 002, 003, accepted every 10 cycles.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the binary-to-BCD converter:
// FSM state encoding, BCD digit width and add-3 threshold.
package conv_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction: digits >= 5 get +3
// so the following left shift carries into the next digit.
module bcd_add3
    import conv_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Correct one digit from its pre-shift value
    always_comb begin
        dout = din;
        if (din >= ADD3_THRESH)
            dout = din + 4'd3;
    end

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter, one bit per cycle.
// Optional BCD_SIGNED_EN: two's complement input, sign on out_neg.
module bcd_converter
    import conv_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_neg,
    output logic                  busy
);

    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  src_q;
    logic [WIDTH-1:0]  src_load;
    logic [WIDTH-1:0]  src_next;
    logic [BW-1:0]     acc_q;
    logic [BW-1:0]     acc_fix;
    logic [BW-1:0]     acc_next;
    logic [CW-1:0]     cnt_q;
    logic [BW-1:0]     bcd_q;
    logic              accept;
    logic              last_shift;

    assign accept     = in_valid && in_ready;
    assign last_shift = (state_q == S_SHIFT) && (cnt_q == CW'(1));

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            bcd_add3 u_add3 (
                .din  (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .dout (acc_fix[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Shift the corrected accumulator and source as one word
    always_comb begin
        {acc_next, src_next} = {acc_fix, src_q} << 1;
    end

`ifdef BCD_SIGNED_EN
    logic sign_q;
    logic neg_q;

    // Load the magnitude; the most negative value wraps to itself
    always_comb begin
        src_load = in_data;
        if (in_data[WIDTH-1])
            src_load = ~in_data + WIDTH'(1);
    end

    // Sign travels with the conversion and lands with the result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            if (accept)
                sign_q <= in_data[WIDTH-1];
            if (last_shift)
                neg_q <= sign_q;
        end
    end

    assign out_neg = neg_q;
`else
    assign src_load = in_data;
    assign out_neg  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept)     state_d = S_SHIFT;
            S_SHIFT: if (last_shift) state_d = S_DONE;
            S_DONE:  if (out_ready)  state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = reset && (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
    end

    // Conversion datapath; result register only updates on DONE entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            bcd_q <= '0;
        end else if (accept) begin
            src_q <= src_load;
            acc_q <= '0;
            cnt_q <= CW'(WIDTH);
        end else if (state_q == S_SHIFT) begin
            src_q <= src_next;
            acc_q <= acc_next;
            cnt_q <= cnt_q - CW'(1);
            if (last_shift)
                bcd_q <= acc_next;
        end
    end

    assign out_bcd = bcd_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Directed self-checking bench for bcd_converter.
// Honors BCD_SIGNED_EN to select the signed vector set.
module tb_bcd_converter;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_bcd;
    logic        out_neg;
    logic        busy;

    int checks;
    int errors;
    int cyc;

    bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_neg   (out_neg),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_conv(input logic [7:0] d, input logic [11:0] exp_bcd,
                           input logic exp_neg, input string tag);
        int   n;
        logic rdy_seen;
        out_ready = 1'b1;
        in_data   = d;
        in_valid  = 1'b1;
        chk({tag, "_rdy_idle"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        n        = 0;
        rdy_seen = 1'b0;
        while (!out_valid && n < 30) begin
            rdy_seen |= in_ready;
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 8);
        chk({tag, "_bcd"}, out_bcd, exp_bcd);
        chk({tag, "_neg"}, out_neg, exp_neg);
        chk({tag, "_rdy_busy"}, rdy_seen, 0);
        chk({tag, "_rdy_done"}, in_ready, 0);
        tick();
        chk({tag, "_vld_idle"}, out_valid, 0);
        chk({tag, "_rdy_back"}, in_ready, 1);
    endtask

    initial begin
        int   n;
        int   t_acc;
        int   t_prev;
        logic bad;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;

        // Reset state
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bcd", out_bcd, 12'h000);
        chk("rst_out_neg", out_neg, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);
        tick();

        // Basic values and boundaries
        do_conv(8'd0,   12'h000, 1'b0, "v0");
        do_conv(8'd255, 12'h255, 1'b0, "v255");
        do_conv(8'd99,  12'h099, 1'b0, "v99");
        do_conv(8'd100, 12'h100, 1'b0, "v100");

        // Backpressure: hold out_ready low 20 cycles
        out_ready = 1'b0;
        in_data   = 8'd42;
        in_valid  = 1'b1;
        tick();
        in_data = 8'd55;
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        chk("bp_lat", n, 8);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b1 || out_bcd !== 12'h042 ||
                in_ready !== 1'b0)
                bad = 1'b1;
            tick();
        end
        chk("bp_stable", bad, 0);
        chk("bp_bcd", out_bcd, 12'h042);
        out_ready = 1'b1;
        tick();
        chk("bp_release_vld", out_valid, 0);
        chk("bp_release_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_accept2", busy, 1);
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        chk("bp_lat2", n, 8);
        chk("bp_bcd2", out_bcd, 12'h055);
        tick();

        // Reset in the middle of a conversion
        in_data  = 8'd200;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_bcd", out_bcd, 12'h000);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rdy", in_ready, 0);
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rel_rdy", in_ready, 1);
        tick();
        do_conv(8'd7, 12'h007, 1'b0, "v7");

`ifdef BCD_SIGNED_EN
        do_conv(8'h80, 12'h128, 1'b1, "s80");
        do_conv(8'hFF, 12'h001, 1'b1, "sFF");
        do_conv(8'h00, 12'h000, 1'b0, "s00");
        do_conv(8'h7F, 12'h127, 1'b0, "s7F");
`else
        do_conv(8'h80, 12'h128, 1'b0, "u80");
        do_conv(8'hFF, 12'h255, 1'b0, "uFF");
`endif

        // Back-to-back with in_valid and out_ready held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        t_prev    = 0;
        for (int i = 1; i <= 3; i++) begin
            in_data = 8'(i);
            n = 0;
            while (!in_ready && n < 30) begin
                tick();
                n++;
            end
            chk("b2b_wait_rdy", in_ready, 1);
            tick();
            t_acc = cyc;
            if (i > 1)
                chk("b2b_interval", t_acc - t_prev, 10);
            t_prev = t_acc;
            n = 0;
            while (!out_valid && n < 30) begin
                tick();
                n++;
            end
            chk("b2b_lat", n, 8);
            chk("b2b_bcd", out_bcd, 12'(i));
            if (i == 3)
                in_valid = 1'b0;
        end
        tick();
        chk("b2b_end_idle", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
